seven_seg_scan_controller: RTL and testbench

Time-multiplexes a multi-digit common-anode seven-segment display, so one shared display_seven_segment decoder can serve all digits. It latches a packed BCD value and selects one digit at a time. For each digit it drives the BCD nibble to the decoder, inserts an anode-off guard interval, then enables that digit's anode for a fixed on-time. The block sits between the counter/datapath logic and the board display pins.

---
 rtl/seven_seg_scan_controller.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// Seven-segment scan controller: time-multiplexes NUM_DIGITS common-anode
// digits through one shared BCD decoder. Each digit slot is an all-off guard
// interval followed by the digit's on-time. New display data is staged and
// committed only at a frame boundary, so a frame never mixes old and new digits.
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [3:0]                    digit_bcd,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done,
  output logic                          load_ack
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int MAX_CYCLES = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    pending;

  logic                    last_idx;
  logic                    guard_end;
  logic                    show_end;
  logic                    boundary;
  logic                    commit;
  logic [IDX_W-1:0]        next_idx;
  logic [4*NUM_DIGITS-1:0] display_next;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   show_anode;

  // Digit i (i>0) is blanked when it and every more-significant digit are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] disp,
    input logic                    en
  );
    logic run;
    run = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run = run & (disp[4*i +: 4] == 4'd0);
      lz_mask[i] = en & run;
    end
  endfunction

  // Slot timing decodes, commit decision and the anode pattern for SHOW entry.
  always_comb begin
    last_idx  = (scan_idx == IDX_LAST);
    guard_end = (cnt == GUARD_LAST);
    show_end  = (cnt == ON_LAST);
    // The final SHOW cycle of the last digit is the frame boundary.
    boundary  = enable && (state == ST_SHOW) && show_end && last_idx;
    commit    = pending && ((state == ST_IDLE) || boundary);
    next_idx  = last_idx ? '0 : scan_idx + 1'b1;
    // Digit 0 of the next frame must come from freshly committed data.
    display_next = commit ? staging : display;
    blank_mask   = lz_mask(display, blank_lz);
    show_anode   = '1;
    if (!blank_mask[scan_idx]) begin
      show_anode[scan_idx] = 1'b0;
    end
  end

  // Load staging and frame-boundary commit into the display register.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging  <= '0;
      display  <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (commit) begin
        display  <= staging;
        pending  <= 1'b0;
        load_ack <= 1'b1;
      end
      // A load on the commit cycle is taken after the commit, so it stays pending.
      if (load) begin
        staging <= value;
        pending <= 1'b1;
      end
    end
  end

  // Scan state machine: IDLE -> (BLANK -> SHOW) per digit, wrapping each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      scan_idx   <= '0;
      anode      <= '1;
      digit_bcd  <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          anode    <= '1;
          scan_idx <= '0;
          cnt      <= '0;
          if (enable) begin
            state     <= ST_BLANK;
            digit_bcd <= display_next[3:0];
          end
        end
        ST_BLANK: begin
          if (!enable) begin
            state    <= ST_IDLE;
            anode    <= '1;
            scan_idx <= '0;
            cnt      <= '0;
          end else if (guard_end) begin
            state <= ST_SHOW;
            cnt   <= '0;
            anode <= show_anode;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (!enable) begin
            state    <= ST_IDLE;
            anode    <= '1;
            scan_idx <= '0;
            cnt      <= '0;
          end else if (show_end) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            anode      <= '1;
            scan_idx   <= next_idx;
            digit_bcd  <= display_next[{next_idx, 2'b00} +: 4];
            frame_done <= last_idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          anode    <= '1;
          scan_idx <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller (4 digits, ON=4, GUARD=1).
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_bcd;
  logic [3:0]  anode;
  logic [1:0]  scan_idx;
  logic        frame_done;
  logic        load_ack;

  int n_vec = 0;
  int n_bad = 0;

  seven_seg_scan_controller #(
    .NUM_DIGITS(4),
    .ON_CYCLES(4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .value(value),
    .load(load),
    .blank_lz(blank_lz),
    .digit_bcd(digit_bcd),
    .anode(anode),
    .scan_idx(scan_idx),
    .frame_done(frame_done),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first (guard) cycle of a slot; walks the whole 5-cycle slot.
  task automatic slot(input string tag, input int idx, input logic [3:0] d,
                      input logic [3:0] an, input logic fd, input logic la,
                      input bit ld_first, input bit ld_last, input logic [15:0] lv);
    chk({tag, "/idx"}, 32'(scan_idx), 32'(idx));
    chk({tag, "/bcd0"}, 32'(digit_bcd), 32'(d));
    chk({tag, "/guard"}, 32'(anode), 32'hF);
    chk({tag, "/fd0"}, 32'(frame_done), 32'(fd));
    chk({tag, "/la0"}, 32'(load_ack), 32'(la));
    if (ld_first) begin
      value = lv;
      load  = 1'b1;
    end
    tick;
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "/an"}, 32'(anode), 32'(an));
      chk({tag, "/bcd"}, 32'(digit_bcd), 32'(d));
      chk({tag, "/fd"}, 32'(frame_done), 32'h0);
      chk({tag, "/la"}, 32'(load_ack), 32'h0);
      if (ld_last && k == 3) begin
        value = lv;
        load  = 1'b1;
      end
      tick;
      load = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; value = 16'h0; load = 1'b0; blank_lz = 1'b0;
    tick; tick;
    chk("rst/anode", 32'(anode), 32'hF);
    chk("rst/bcd", 32'(digit_bcd), 32'h0);
    chk("rst/idx", 32'(scan_idx), 32'h0);
    chk("rst/fd", 32'(frame_done), 32'h0);
    chk("rst/la", 32'(load_ack), 32'h0);
    reset = 1'b0;

    // Load while idle: commit and load_ack one cycle later.
    value = 16'h1234; load = 1'b1;
    tick;
    load = 1'b0;
    chk("idle/la_early", 32'(load_ack), 32'h0);
    tick;
    chk("idle/la", 32'(load_ack), 32'h1);
    enable = 1'b1;
    tick;

    // Frame 1: 1234, mid-frame load of 5678 at digit 1 in frame 2.
    slot("f1d0", 0, 4'h4, 4'hE, 0, 0, 0, 0, 16'h0);
    slot("f1d1", 1, 4'h3, 4'hD, 0, 0, 0, 0, 16'h0);
    slot("f1d2", 2, 4'h2, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f1d3", 3, 4'h1, 4'h7, 0, 0, 0, 0, 16'h0);
    slot("f2d0", 0, 4'h4, 4'hE, 1, 0, 0, 0, 16'h0);
    slot("f2d1", 1, 4'h3, 4'hD, 0, 0, 1, 0, 16'h5678);
    slot("f2d2", 2, 4'h2, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f2d3", 3, 4'h1, 4'h7, 0, 0, 0, 0, 16'h0);
    // Frame 3: 5678 with frame_done and load_ack together; two loads inside.
    slot("f3d0", 0, 4'h8, 4'hE, 1, 1, 1, 0, 16'h1111);
    slot("f3d1", 1, 4'h7, 4'hD, 0, 0, 1, 0, 16'h2222);
    slot("f3d2", 2, 4'h6, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f3d3", 3, 4'h5, 4'h7, 0, 0, 0, 0, 16'h0);
    // Frame 4: 2222 (last load wins); load 3333, then a load on the boundary.
    slot("f4d0", 0, 4'h2, 4'hE, 1, 1, 0, 0, 16'h0);
    slot("f4d1", 1, 4'h2, 4'hD, 0, 0, 1, 0, 16'h3333);
    slot("f4d2", 2, 4'h2, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f4d3", 3, 4'h2, 4'h7, 0, 0, 0, 1, 16'h9876);
    // Frame 5: boundary commit used pre-load staging (3333); 9876 stays pending.
    slot("f5d0", 0, 4'h3, 4'hE, 1, 1, 0, 0, 16'h0);
    slot("f5d1", 1, 4'h3, 4'hD, 0, 0, 0, 0, 16'h0);
    slot("f5d2", 2, 4'h3, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f5d3", 3, 4'h3, 4'h7, 0, 0, 0, 0, 16'h0);
    // Frame 6: 9876 one frame later; enable leading-zero blanking, load 0040.
    blank_lz = 1'b1;
    slot("f6d0", 0, 4'h6, 4'hE, 1, 1, 1, 0, 16'h0040);
    slot("f6d1", 1, 4'h7, 4'hD, 0, 0, 0, 0, 16'h0);
    slot("f6d2", 2, 4'h8, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("f6d3", 3, 4'h9, 4'h7, 0, 0, 0, 0, 16'h0);
    // Frame 7: 0040 -> digits 3,2 dark; then load 0000.
    slot("f7d0", 0, 4'h0, 4'hE, 1, 1, 0, 0, 16'h0);
    slot("f7d1", 1, 4'h4, 4'hD, 0, 0, 1, 0, 16'h0000);
    slot("f7d2", 2, 4'h0, 4'hF, 0, 0, 0, 0, 16'h0);
    slot("f7d3", 3, 4'h0, 4'hF, 0, 0, 0, 0, 16'h0);
    // Frame 8: 0000 -> only digit 0 lit; reload 1234.
    slot("f8d0", 0, 4'h0, 4'hE, 1, 1, 0, 0, 16'h0);
    slot("f8d1", 1, 4'h0, 4'hF, 0, 0, 1, 0, 16'h1234);
    slot("f8d2", 2, 4'h0, 4'hF, 0, 0, 0, 0, 16'h0);
    slot("f8d3", 3, 4'h0, 4'hF, 0, 0, 0, 0, 16'h0);
    blank_lz = 1'b0;
    slot("f9d0", 0, 4'h4, 4'hE, 1, 1, 0, 0, 16'h0);
    slot("f9d1", 1, 4'h3, 4'hD, 0, 0, 0, 0, 16'h0);

    // Drop enable during SHOW of digit 2.
    chk("dis/idx2", 32'(scan_idx), 32'h2);
    tick;
    chk("dis/show_an", 32'(anode), 32'hB);
    tick;
    enable = 1'b0;
    tick;
    chk("dis/anode", 32'(anode), 32'hF);
    chk("dis/idx", 32'(scan_idx), 32'h0);
    chk("dis/fd", 32'(frame_done), 32'h0);
    tick;
    chk("dis/anode_hold", 32'(anode), 32'hF);
    enable = 1'b1;
    tick;
    slot("re_d0", 0, 4'h4, 4'hE, 0, 0, 0, 0, 16'h0);
    slot("re_d1", 1, 4'h3, 4'hD, 0, 0, 0, 0, 16'h0);
    slot("re_d2", 2, 4'h2, 4'hB, 0, 0, 0, 0, 16'h0);
    slot("re_d3", 3, 4'h1, 4'h7, 0, 0, 0, 0, 16'h0);

    // Reset in the middle of SHOW of digit 0.
    chk("mr/fd", 32'(frame_done), 32'h1);
    tick;
    tick;
    chk("mr/an_pre", 32'(anode), 32'hE);
    reset = 1'b1;
    tick;
    chk("mr/anode", 32'(anode), 32'hF);
    chk("mr/bcd", 32'(digit_bcd), 32'h0);
    chk("mr/idx", 32'(scan_idx), 32'h0);
    chk("mr/fd0", 32'(frame_done), 32'h0);
    chk("mr/la0", 32'(load_ack), 32'h0);
    reset = 1'b0;
    tick;
    // Display register was cleared: digits show 0.
    slot("mr_d0", 0, 4'h0, 4'hE, 0, 0, 0, 0, 16'h0);
    slot("mr_d1", 1, 4'h0, 4'hD, 0, 0, 0, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
